wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline, directly upstream of the register file.
- Captures one retiring instruction from the memory stage and, for loads, waits for the data-memory response.
- Selects and formats the result, then drives the register file write port (WrEn_RF, WAddr_RF, WD_RF) for exactly one cycle.
- Also exports bypass and load-pending information to the hazard/forwarding logic.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width.
- CNT_W, 32, width of the retire counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_MEM  in  1  memory stage presents an instruction.
- ready_WB  out  1  stage can accept this cycle.
- rd_MEM  in  AW  destination register.
- regwr_MEM  in  1  instruction writes rd.
- wbsel_MEM  in  2  result select: 00 ALU, 01 LOAD, 10 PC+4, 11 treated as ALU.
- alu_MEM  in  XLEN  ALU result.
- pc4_MEM  in  XLEN  PC+4.
- f3_MEM  in  3  load funct3.
- off_MEM  in  2  load byte offset (address bits 1:0).
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  raw aligned load word.
- WrEn_RF  out  1  register file write enable.
- WAddr_RF  out  AW  register file write address.
- WD_RF  out  XLEN  register file write data.
- ldpend_WB  out  1  load awaiting response.
- ldrd_WB  out  AW  rd of the pending load; 0 when ldpend_WB=0.

Behaviour:
- States:
  - IDLE: empty.
  - WAIT_LD: load captured, waiting for data.
  - WRITE: result valid and committing this cycle.
  - Reset state is IDLE. All registered fields and outputs reset to 0.
- ready_WB = (state==IDLE) || (state==WRITE).
- Capture happens at posedge when valid_MEM && ready_WB:
  - wbsel==01 goes to WAIT_LD.
  - Any other wbsel goes to WRITE.
  - No capture from IDLE stays IDLE; no capture from WRITE goes to IDLE.
- Back-to-back: a new instruction captured in WRITE commits on the following cycle, giving throughput of 1 per cycle for non-loads.
- WAIT_LD:
  - ready_WB=0.
  - On posedge with dmem_rvalid=1, latch the formatted load data and go to WRITE.
  - dmem_rvalid is ignored in every other state.
  - Wait length is unbounded.
- Latency:
  - Non-load captured at edge N: WrEn_RF is high during cycle N..N+1 and the register file writes at edge N+1.
  - Load: WRITE occurs in the cycle after the dmem_rvalid edge.
- WrEn_RF = (state==WRITE) && regwr && (rd!=0).
  - WAddr_RF and WD_RF hold the captured values in WRITE and are 0 otherwise.
  - These are combinational decodes of registered state; there is no combinational path from any *_MEM input to them.
- Load formatting, on dmem_rdata with offset o:
  - LB 000: sign-extend byte o.
  - LBU 100: zero-extend byte o.
  - LH 001: sign-extend half o[1].
  - LHU 101: zero-extend half o[1].
  - LW 010: full word; o is ignored.
  - Other funct3 values: treated as LW.
  - o[0] is ignored for halfwords. Misalignment is trapped upstream.
- ldpend_WB = (state==WAIT_LD). ldrd_WB = captured rd in that state.
- rd==0 with regwr=1: passes through WRITE with WrEn_RF=0 and still counts as retired.
- Reset mid-operation (WAIT_LD or WRITE): the state goes to IDLE immediately and WrEn_RF drops immediately. A late dmem_rvalid after reset is ignored.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret_WB [CNT_W-1:0].
  - It increments by 1 on every posedge where state==WRITE, regardless of regwr or rd.
  - Wraps modulo 2^CNT_W and resets to 0.
- Undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - wbsel encodings (WB_ALU, WB_LOAD, WB_PC4);
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - state enum (WB_IDLE, WB_WAIT_LD, WB_WRITE);
  - XLEN and AW defaults.
- One sub-module is natural: load_fmt, a purely combinational extractor/extender taking (rdata, f3, off) and producing data. The FSM and registers stay in wb_stage.

Test Plan:
- ALU op, rd=5, alu=0x0000_1234, wbsel=00: one cycle later WrEn_RF=1, WAddr_RF=5, WD_RF=0x0000_1234. The next cycle WrEn_RF=0 when valid_MEM=0.
- Three back-to-back non-loads (rd 1,2,3): ready_WB stays 1. WrEn_RF is high on three consecutive cycles with addresses 1,2,3.
- LB rd=7, off=3, dmem_rdata=0x80FF_0102 arriving 3 cycles after capture:
  - ready_WB=0 and ldpend_WB=1 with ldrd_WB=7 while waiting.
  - Then WD_RF=0xFFFF_FF80.
  - Repeat with LBU to get 0x0000_0080; LH off=2 to get 0xFFFF_80FF; LHU off=2 to get 0x0000_80FF.
- wbsel=10, pc4=0x0000_0104, rd=1: WD_RF=0x0000_0104. With rd=0 and regwr=1: WrEn_RF stays 0 and instret increments (WB_RETIRE_CNT_EN build).
- rst_n asserted during WAIT_LD, then dmem_rvalid pulsed after release: state is IDLE, no write occurs, ready_WB=1, ldpend_WB=0, and instret=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: result-select and load funct3 encodings,
// the stage state enum, and default datapath widths.
package wb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_WAIT_LD = 2'd1,
        WB_WRITE   = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_stage_load_fmt.sv
// Combinational load extractor: picks the byte/half addressed by off from the
// aligned word and sign- or zero-extends it according to funct3.
module load_fmt
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      f3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*off +: 8];
        // Halfwords are assumed aligned, so only off[1] chooses the half.
        half_sel = rdata[16*off[1] +: 16];
        case (f3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: captures one retiring instruction, waits for load data,
// and drives the register-file write port. WB_RETIRE_CNT_EN adds instret_WB.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_MEM,
    output logic            ready_WB,
    input  logic [AW-1:0]   rd_MEM,
    input  logic            regwr_MEM,
    input  logic [1:0]      wbsel_MEM,
    input  logic [XLEN-1:0] alu_MEM,
    input  logic [XLEN-1:0] pc4_MEM,
    input  logic [2:0]      f3_MEM,
    input  logic [1:0]      off_MEM,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            WrEn_RF,
    output logic [AW-1:0]   WAddr_RF,
    output logic [XLEN-1:0] WD_RF,
    output logic            ldpend_WB,
    output logic [AW-1:0]   ldrd_WB
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] instret_WB
`endif
);
    wb_state_e       state_q, state_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            regwr_q, regwr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] ld_data;

    load_fmt #(.XLEN(XLEN)) u_load_fmt (
        .rdata (dmem_rdata),
        .f3    (f3_q),
        .off   (off_q),
        .data  (ld_data)
    );

    assign ready_WB = (state_q == WB_IDLE) || (state_q == WB_WRITE);

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        regwr_d = regwr_q;
        data_d  = data_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            WB_IDLE, WB_WRITE: begin
                if (valid_MEM) begin
                    rd_d    = rd_MEM;
                    regwr_d = regwr_MEM;
                    f3_d    = f3_MEM;
                    off_d   = off_MEM;
                    case (wbsel_MEM)
                        WB_LOAD: state_d = WB_WAIT_LD;
                        WB_PC4: begin
                            data_d  = pc4_MEM;
                            state_d = WB_WRITE;
                        end
                        WB_ALU: begin
                            data_d  = alu_MEM;
                            state_d = WB_WRITE;
                        end
                        default: begin
                            data_d  = alu_MEM;
                            state_d = WB_WRITE;
                        end
                    endcase
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT_LD: begin
                if (dmem_rvalid) begin
                    data_d  = ld_data;
                    state_d = WB_WRITE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            rd_q    <= '0;
            regwr_q <= 1'b0;
            data_q  <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            regwr_q <= regwr_d;
            data_q  <= data_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    // Outputs decode registered state only; nothing from *_MEM reaches them.
    assign WrEn_RF   = (state_q == WB_WRITE) && regwr_q && (rd_q != '0);
    assign WAddr_RF  = (state_q == WB_WRITE) ? rd_q : '0;
    assign WD_RF     = (state_q == WB_WRITE) ? data_q : '0;
    assign ldpend_WB = (state_q == WB_WAIT_LD);
    assign ldrd_WB   = (state_q == WB_WAIT_LD) ? rd_q : '0;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (state_q == WB_WRITE) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instret_WB = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register writes are queued at issue
// and popped whenever WrEn_RF is seen on the falling edge.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_MEM;
    logic        ready_WB;
    logic [4:0]  rd_MEM;
    logic        regwr_MEM;
    logic [1:0]  wbsel_MEM;
    logic [31:0] alu_MEM, pc4_MEM;
    logic [2:0]  f3_MEM;
    logic [1:0]  off_MEM;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        WrEn_RF;
    logic [4:0]  WAddr_RF;
    logic [31:0] WD_RF;
    logic        ldpend_WB;
    logic [4:0]  ldrd_WB;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] instret_WB;
`endif

    int n_chk = 0;
    int n_err = 0;
    int exp_ret = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_MEM(valid_MEM), .ready_WB(ready_WB),
        .rd_MEM(rd_MEM), .regwr_MEM(regwr_MEM), .wbsel_MEM(wbsel_MEM),
        .alu_MEM(alu_MEM), .pc4_MEM(pc4_MEM), .f3_MEM(f3_MEM), .off_MEM(off_MEM),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .WrEn_RF(WrEn_RF), .WAddr_RF(WAddr_RF), .WD_RF(WD_RF),
        .ldpend_WB(ldpend_WB), .ldrd_WB(ldrd_WB)
`ifdef WB_RETIRE_CNT_EN
        , .instret_WB(instret_WB)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && WrEn_RF) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {27'd0, WAddr_RF}, 32'd0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("waddr", {27'd0, WAddr_RF}, {27'd0, e[36:32]});
                chk("wdata", WD_RF, e[31:0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the capture edge.
    task automatic drive_op(input logic [4:0] rd, input logic regwr, input logic [1:0] wbsel,
                            input logic [31:0] alu, input logic [31:0] pc4,
                            input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] exp, input bit push);
        chk("ready_at_issue", {31'd0, ready_WB}, 32'd1);
        valid_MEM = 1'b1; rd_MEM = rd; regwr_MEM = regwr; wbsel_MEM = wbsel;
        alu_MEM = alu; pc4_MEM = pc4; f3_MEM = f3; off_MEM = off;
        if (push && regwr && rd != 5'd0) sb_q.push_back({rd, exp});
        if (push && wbsel != 2'b01) exp_ret++;
        @(posedge clk); #1;
        valid_MEM = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] rdata, input logic [31:0] exp, input int waitn);
        drive_op(rd, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0, f3, off, exp, 1'b1);
        for (int i = 0; i < waitn; i++) begin
            chk("ld_ready", {31'd0, ready_WB}, 32'd0);
            chk("ld_pend", {31'd0, ldpend_WB}, 32'd1);
            chk("ld_rd", {27'd0, ldrd_WB}, {27'd0, rd});
            dmem_rdata = 32'h5555_5555;
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        exp_ret++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_ret(input string tag);
`ifdef WB_RETIRE_CNT_EN
        chk(tag, instret_WB, exp_ret);
`else
        chk(tag, 32'(exp_ret), 32'(exp_ret));
`endif
    endtask

    initial begin
        rst_n = 1'b0; valid_MEM = 1'b0; rd_MEM = '0; regwr_MEM = 1'b0; wbsel_MEM = '0;
        alu_MEM = '0; pc4_MEM = '0; f3_MEM = '0; off_MEM = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        idle(2);
        chk("rst_ready", {31'd0, ready_WB}, 32'd1);
        chk("rst_wren", {31'd0, WrEn_RF}, 32'd0);
        chk("rst_waddr", {27'd0, WAddr_RF}, 32'd0);
        chk("rst_wd", WD_RF, 32'd0);
        chk("rst_ldpend", {31'd0, ldpend_WB}, 32'd0);
        chk("rst_ldrd", {27'd0, ldrd_WB}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Single ALU op followed by an empty cycle
        drive_op(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0, 3'd0, 2'd0, 32'h0000_1234, 1'b1);
        idle(1);
        chk("alu_then_idle_wren", {31'd0, WrEn_RF}, 32'd0);
        idle(1);

        // Three back-to-back non-loads; ready is checked at each issue
        drive_op(5'd1, 1'b1, 2'b00, 32'h1111_0001, 32'h0, 3'd0, 2'd0, 32'h1111_0001, 1'b1);
        drive_op(5'd2, 1'b1, 2'b11, 32'h2222_0002, 32'h0, 3'd0, 2'd0, 32'h2222_0002, 1'b1);
        drive_op(5'd3, 1'b1, 2'b10, 32'h0, 32'h3333_0003, 3'd0, 2'd0, 32'h3333_0003, 1'b1);
        idle(2);

        do_load(5'd7, 3'b000, 2'd3, 32'h80FF_0102, 32'hFFFF_FF80, 3);
        do_load(5'd8, 3'b100, 2'd3, 32'h80FF_0102, 32'h0000_0080, 3);
        do_load(5'd9, 3'b001, 2'd2, 32'h80FF_0102, 32'hFFFF_80FF, 1);
        do_load(5'd10, 3'b101, 2'd3, 32'h80FF_0102, 32'h0000_80FF, 0);
        do_load(5'd11, 3'b010, 2'd1, 32'h80FF_0102, 32'h80FF_0102, 2);
        do_load(5'd12, 3'b000, 2'd0, 32'h80FF_0182, 32'hFFFF_FF82, 0);
        do_load(5'd13, 3'b111, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);

        // Stray rvalid while idle must be ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        idle(1);
        dmem_rvalid = 1'b0;
        chk("stray_rvalid_ldpend", {31'd0, ldpend_WB}, 32'd0);

        drive_op(5'd1, 1'b1, 2'b10, 32'h0, 32'h0000_0104, 3'd0, 2'd0, 32'h0000_0104, 1'b1);
        drive_op(5'd0, 1'b1, 2'b10, 32'h0, 32'h0000_0200, 3'd0, 2'd0, 32'h0, 1'b1);
        chk("rd0_wren", {31'd0, WrEn_RF}, 32'd0);
        drive_op(5'd4, 1'b0, 2'b00, 32'h0000_0444, 32'h0, 3'd0, 2'd0, 32'h0, 1'b1);
        chk("noregwr_wren", {31'd0, WrEn_RF}, 32'd0);
        idle(2);
        chk_ret("instret");
        chk("sb_drained", sb_q.size(), 32'd0);

        // Reset while a load is outstanding, then a late rvalid
        drive_op(5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0, 32'h0, 1'b0);
        chk("pre_rst_ldpend", {31'd0, ldpend_WB}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("rst_mid_wren", {31'd0, WrEn_RF}, 32'd0);
        chk("rst_mid_ldpend", {31'd0, ldpend_WB}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        idle(1);
        dmem_rvalid = 1'b0;
        chk("post_rst_wren", {31'd0, WrEn_RF}, 32'd0);
        chk("post_rst_ready", {31'd0, ready_WB}, 32'd1);
        chk("post_rst_ldpend", {31'd0, ldpend_WB}, 32'd0);
        idle(2);
        chk_ret("post_rst_instret");

        // Reset during WRITE drops the write enable immediately
        drive_op(5'd6, 1'b1, 2'b00, 32'h0000_0066, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0);
        chk("pre_rst_wren", {31'd0, WrEn_RF}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("rst_write_wren", {31'd0, WrEn_RF}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        chk_ret("rst_write_instret");
        chk("sb_final", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
